// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared types for the five-stage MIPS pipeline control logic.
//            Holds the register-index width and the hazard controller state.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    // Width of an architectural register index
    localparam int unsigned c_REG_W = 5;

    // Hazard controller operating modes
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Flags a load in EX whose destination is read by the ID
//            instruction. Register 0 never creates a dependency.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic               i_memtoReg_EX,
    input  logic [c_REG_W-1:0] i_final_wsel_EX,
    input  logic [c_REG_W-1:0] i_rs_ID,
    input  logic [c_REG_W-1:0] i_rt_ID,
    input  logic               i_uses_rt_ID,
    output logic               o_lu
);

    logic w_rs_match;
    logic w_rt_match;

    // Dependency on either source operand of the ID instruction
    always_comb begin
        w_rs_match = (i_final_wsel_EX == i_rs_ID);
        w_rt_match = i_uses_rt_ID & (i_final_wsel_EX == i_rt_ID);
        o_lu       = i_memtoReg_EX & (i_final_wsel_EX != '0) & (w_rs_match | w_rt_match);
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Central stall/flush controller for the five-stage pipeline.
//            Drives pc_en plus enable/flush of IF/ID, ID/EX, EX/MEM, MEM/WB
//            and drains the pipeline on halt before reporting halted.
//            Optional macro HAZARD_PERF_EN adds stall_cnt / flush_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int HALT_DRAIN = 2
)
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               dmem_req_MEM,
    input  logic               memtoReg_EX,
    input  logic [c_REG_W-1:0] final_wsel_EX,
    input  logic [c_REG_W-1:0] rs_ID,
    input  logic [c_REG_W-1:0] rt_ID,
    input  logic               uses_rt_ID,
    input  logic               jump_ID,
    input  logic               branch_taken_EX,
    input  logic               halt_EX,
    output logic               pc_en,
    output logic               ifid_enable,
    output logic               ifid_flush,
    output logic               idex_enable,
    output logic               idex_flush,
    output logic               exmem_enable,
    output logic               exmem_flush,
    output logic               memwb_enable,
    output logic               memwb_flush,
    output logic               halt
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    // Last drain count value before entering HALTED
    localparam logic [1:0] c_DRAIN_LAST = 2'(HALT_DRAIN - 1);

    hazard_state_t r_state;
    logic [1:0]    r_dcnt;
    logic          r_halt;
    logic          w_mstall;
    logic          w_lu;

    assign w_mstall = dmem_req_MEM & ~dhit;
    assign halt     = r_halt;

    load_use_detect u_load_use_detect (
        .i_memtoReg_EX   (memtoReg_EX),
        .i_final_wsel_EX (final_wsel_EX),
        .i_rs_ID         (rs_ID),
        .i_rt_ID         (rt_ID),
        .i_uses_rt_ID    (uses_rt_ID),
        .o_lu            (w_lu)
    );

    // Latch controls: reset, halted and memory stall dominate, then redirects
    always_comb begin
        pc_en        = ihit;
        ifid_enable  = 1'b1;
        ifid_flush   = 1'b0;
        idex_enable  = 1'b1;
        idex_flush   = 1'b0;
        exmem_enable = 1'b1;
        exmem_flush  = 1'b0;
        memwb_enable = 1'b1;
        memwb_flush  = 1'b0;
        if (RST) begin
            pc_en        = 1'b0;
            ifid_enable  = 1'b0;
            ifid_flush   = 1'b1;
            idex_enable  = 1'b0;
            idex_flush   = 1'b1;
            exmem_enable = 1'b0;
            exmem_flush  = 1'b1;
            memwb_enable = 1'b0;
            memwb_flush  = 1'b1;
        end else if (r_state == HALTED) begin
            pc_en        = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_enable = 1'b0;
        end else if (w_mstall) begin
            // Freeze everything upstream of MEM; WB gets a bubble
            pc_en        = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_flush  = 1'b1;
        end else if (r_state == DRAIN) begin
            // Stop fetching and let older instructions retire
            pc_en        = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (branch_taken_EX) begin
            pc_en        = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (w_lu) begin
            // One bubble: hold PC and IF/ID, squash ID/EX
            pc_en        = 1'b0;
            ifid_enable  = 1'b0;
            idex_flush   = 1'b1;
        end else if (jump_ID || !ihit) begin
            ifid_flush   = 1'b1;
        end
    end

    // Halt sequencing: RUN -> DRAIN -> HALTED, left only via reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
            r_dcnt  <= 2'd0;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (halt_EX && !w_mstall) begin
                        r_state <= DRAIN;
                        r_dcnt  <= 2'd0;
                    end
                end
                DRAIN: begin
                    if (!w_mstall) begin
                        r_dcnt <= r_dcnt + 2'd1;
                        if (r_dcnt == c_DRAIN_LAST) begin
                            r_state <= HALTED;
                            r_halt  <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= RUN;
                    r_dcnt  <= 2'd0;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // Performance counters advance only while running; wrap naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else if (r_state == RUN) begin
            if (w_mstall || w_lu || !ihit) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (branch_taken_EX || jump_ID) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Self-checking bench for pipeline_hazard_ctrl. A rule-based
//            reference model predicts every latch control and halt each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int HALT_DRAIN = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, dmem_req_MEM, memtoReg_EX;
    logic [4:0] final_wsel_EX, rs_ID, rt_ID;
    logic       uses_rt_ID, jump_ID, branch_taken_EX, halt_EX;
    logic       pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush;
    logic       exmem_enable, exmem_flush, memwb_enable, memwb_flush, halt;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    int unsigned m_stall, m_flush;
`endif

    pipeline_hazard_ctrl #(.HALT_DRAIN(HALT_DRAIN)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .ihit            (ihit),
        .dhit            (dhit),
        .dmem_req_MEM    (dmem_req_MEM),
        .memtoReg_EX     (memtoReg_EX),
        .final_wsel_EX   (final_wsel_EX),
        .rs_ID           (rs_ID),
        .rt_ID           (rt_ID),
        .uses_rt_ID      (uses_rt_ID),
        .jump_ID         (jump_ID),
        .branch_taken_EX (branch_taken_EX),
        .halt_EX         (halt_EX),
        .pc_en           (pc_en),
        .ifid_enable     (ifid_enable),
        .ifid_flush      (ifid_flush),
        .idex_enable     (idex_enable),
        .idex_flush      (idex_flush),
        .exmem_enable    (exmem_enable),
        .exmem_flush     (exmem_flush),
        .memwb_enable    (memwb_enable),
        .memwb_flush     (memwb_flush),
        .halt            (halt)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: halted flag, draining flag, non-stalled cycles left
    bit m_halted;
    bit m_draining;
    int m_left;
    bit m_known;
    int cyc;

    // Expected controls packed as {pc, ifid_en, ifid_fl, idex_en, idex_fl,
    // exmem_en, exmem_fl, memwb_en, memwb_fl}
    function automatic logic [8:0] ref_ctrl();
        logic mst, luse;
        logic pc, fe, ff, de, df, xe, xf, we, wf;
        mst  = dmem_req_MEM && !dhit;
        luse = memtoReg_EX && final_wsel_EX != 0 &&
               (final_wsel_EX == rs_ID || (uses_rt_ID && final_wsel_EX == rt_ID));
        pc = ihit; fe = 1; ff = 0; de = 1; df = 0; xe = 1; xf = 0; we = 1; wf = 0;
        if (RST) begin
            pc = 0; fe = 0; ff = 1; de = 0; df = 1; xe = 0; xf = 1; we = 0; wf = 1;
        end else if (m_halted) begin
            pc = 0; fe = 0; de = 0; xe = 0; we = 0;
        end else if (mst) begin
            pc = 0; fe = 0; de = 0; xe = 0; wf = 1;
        end else if (m_draining) begin
            pc = 0; ff = 1; df = 1;
        end else if (branch_taken_EX) begin
            pc = 1; ff = 1; df = 1;
        end else if (luse) begin
            pc = 0; fe = 0; df = 1;
        end else if (jump_ID) begin
            ff = 1;
        end else if (!ihit) begin
            ff = 1;
        end
        return {pc, fe, ff, de, df, xe, xf, we, wf};
    endfunction

    // Advance the model by one clock edge using the inputs applied this cycle
    task automatic model_edge();
        logic mst, luse;
        mst  = dmem_req_MEM && !dhit;
        luse = memtoReg_EX && final_wsel_EX != 0 &&
               (final_wsel_EX == rs_ID || (uses_rt_ID && final_wsel_EX == rt_ID));
        if (RST) begin
            m_halted = 0; m_draining = 0; m_left = 0; m_known = 1;
`ifdef HAZARD_PERF_EN
            m_stall = 0; m_flush = 0;
`endif
        end else if (!m_halted && m_draining) begin
            if (!mst) begin
                if (m_left == 1) begin
                    m_draining = 0;
                    m_halted   = 1;
                end else begin
                    m_left = m_left - 1;
                end
            end
        end else if (!m_halted) begin
`ifdef HAZARD_PERF_EN
            if (mst || luse || !ihit) m_stall = m_stall + 1;
            if (branch_taken_EX || jump_ID) m_flush = m_flush + 1;
`endif
            if (halt_EX && !mst) begin
                m_draining = 1;
                m_left     = HALT_DRAIN;
            end
        end
    endtask

    // Compare this cycle, then cross the clock edge
    task automatic cycle(input string name);
        logic [8:0] got, exp;
        #3;
        exp = ref_ctrl();
        got = {pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush,
               exmem_enable, exmem_flush, memwb_enable, memwb_flush};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d ctrl got %b expected %b", name, cyc, got, exp);
        end
        if (m_known) begin
            checks++;
            if (halt !== m_halted) begin
                errors++;
                $display("FAIL %s cyc=%0d halt got %b expected %b", name, cyc, halt, m_halted);
            end
        end
`ifdef HAZARD_PERF_EN
        if (m_known) begin
            checks++;
            if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                errors++;
                $display("FAIL %s cyc=%0d perf got %0d/%0d expected %0d/%0d",
                         name, cyc, stall_cnt, flush_cnt, m_stall, m_flush);
            end
        end
`endif
        @(posedge CLK);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        RST = 0; ihit = 1; dhit = 1; dmem_req_MEM = 0; memtoReg_EX = 0;
        final_wsel_EX = 0; rs_ID = 0; rt_ID = 0; uses_rt_ID = 0;
        jump_ID = 0; branch_taken_EX = 0; halt_EX = 0;
    endtask

    task automatic random_inputs(input bit allow_halt);
        ihit            = ($urandom_range(0, 3) != 0);
        dhit            = $urandom_range(0, 1) == 1;
        dmem_req_MEM    = ($urandom_range(0, 3) == 0);
        memtoReg_EX     = $urandom_range(0, 1) == 1;
        final_wsel_EX   = 5'($urandom_range(0, 3));
        rs_ID           = 5'($urandom_range(0, 3));
        rt_ID           = 5'($urandom_range(0, 3));
        uses_rt_ID      = $urandom_range(0, 1) == 1;
        jump_ID         = ($urandom_range(0, 4) == 0);
        branch_taken_EX = ($urandom_range(0, 4) == 0);
        halt_EX         = allow_halt && ($urandom_range(0, 5) == 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1;
        cycle("reset");
        RST = 0;
    endtask

    task automatic test_reset();
        m_known = 0;
        idle_inputs();
        RST = 1;
        cycle("reset_hold");
        cycle("reset_hold2");
        RST = 0;
        cycle("run_default");
    endtask

    task automatic test_load_use();
        idle_inputs();
        memtoReg_EX = 1; final_wsel_EX = 5; rs_ID = 5;
        checks++;
        #3;
        if (pc_en !== 1'b0 || ifid_enable !== 1'b0 || idex_flush !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall got pc=%b ifid_en=%b idex_fl=%b expected 0 0 1",
                     pc_en, ifid_enable, idex_flush);
        end
        #(-0);
        cycle("load_use");
        idle_inputs();
        cycle("after_load_use");
        memtoReg_EX = 1; final_wsel_EX = 0; rs_ID = 0;
        cycle("load_r0");
        memtoReg_EX = 1; final_wsel_EX = 7; rt_ID = 7; uses_rt_ID = 1; ihit = 0;
        cycle("load_use_rt_nohit");
        idle_inputs();
        memtoReg_EX = 1; final_wsel_EX = 7; rt_ID = 7; uses_rt_ID = 0;
        cycle("load_rt_unused");
        idle_inputs();
    endtask

    task automatic test_mstall_branch();
        idle_inputs();
        dmem_req_MEM = 1; dhit = 0; branch_taken_EX = 1; jump_ID = 1;
        for (int i = 0; i < 3; i++) cycle("mstall_branch");
        dhit = 1;
        cycle("branch_after_mstall");
        idle_inputs();
        branch_taken_EX = 1; ihit = 0;
        cycle("branch_nohit");
        idle_inputs();
        jump_ID = 1; ihit = 0;
        cycle("jump_nohit");
        idle_inputs();
    endtask

    task automatic test_random_run();
        for (int i = 0; i < 300; i++) begin
            random_inputs(1'b0);
            cycle("random_run");
        end
        idle_inputs();
    endtask

    // Count cycles from halt acceptance until halt is seen, with a bound
    task automatic test_halt(input bit with_mstall, input int expect_lat);
        int lat;
        do_reset();
        idle_inputs();
        halt_EX = 1;
        cycle("halt_accept");
        halt_EX = 0;
        lat = 1;
        while (halt !== 1'b1 && lat < 20) begin
            if (with_mstall && lat == 1) begin
                dmem_req_MEM = 1; dhit = 0;
            end else begin
                idle_inputs();
            end
            cycle("halt_drain");
            lat++;
        end
        checks++;
        if (lat != expect_lat) begin
            errors++;
            $display("FAIL halt_latency got %0d expected %0d", lat, expect_lat);
        end
        for (int i = 0; i < 3; i++) begin
            random_inputs(1'b1);
            cycle("halted_hold");
        end
        idle_inputs();
        RST = 1;
        cycle("reset_in_halted");
        RST = 0;
        cycle("run_after_halt_reset");
    endtask

    task automatic test_random_halt();
        for (int n = 0; n < 6; n++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                random_inputs(1'b1);
                if (i == 25 && n[0]) RST = 1;
                cycle("random_halt");
                RST = 0;
            end
        end
        idle_inputs();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        do_reset();
        idle_inputs();
        memtoReg_EX = 1; final_wsel_EX = 3; rs_ID = 3;
        cycle("perf_lu1");
        idle_inputs();
        cycle("perf_idle");
        memtoReg_EX = 1; final_wsel_EX = 4; rt_ID = 4; uses_rt_ID = 1;
        cycle("perf_lu2");
        idle_inputs();
        jump_ID = 1;
        cycle("perf_jump");
        idle_inputs();
        #3;
        checks++;
        if (stall_cnt !== 32'd2 || flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf_counts got %0d/%0d expected 2/1", stall_cnt, flush_cnt);
        end
        @(negedge CLK);
        dut.r_stall_cnt = 32'hFFFF_FFFF;
        m_stall = 32'hFFFF_FFFF;
        @(posedge CLK);
        #1;
        ihit = 0;
        cycle("perf_wrap");
        idle_inputs();
        #3;
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_wrap got %0d expected 0", stall_cnt);
        end
        #2;
    endtask
`endif

    initial begin
        m_halted = 0; m_draining = 0; m_left = 0; m_known = 0; cyc = 0;
`ifdef HAZARD_PERF_EN
        m_stall = 0; m_flush = 0;
`endif
        idle_inputs();
        RST = 1;
        #1;
        test_reset();
        test_load_use();
        test_mstall_branch();
        test_random_run();
        test_halt(1'b0, 3);
        test_halt(1'b1, 4);
        test_random_halt();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
